// File: rtl/fetch_ctrl.sv
// fetch_ctrl: fetch-stage sequencer owning the PC, a one-entry instruction buffer and branch redirects
// Ports: clk, reset (asynchronous, active-low);
//   redirect_valid/redirect_pc from later stages;
//   imem_req/imem_addr/imem_ready/imem_rvalid/imem_rdata to the instruction memory;
//   inst_valid/inst_ready/inst_pc/inst_out to decode;
//   perf_fetched/perf_stall/perf_redirect counters, present only when FETCH_CTRL_PERF_EN is defined.
module fetch_ctrl #(
  parameter logic [31:0] RESET_PC = 32'h0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst_pc,
  output logic [31:0] inst_out
`ifdef FETCH_CTRL_PERF_EN
  ,
  output logic [31:0] perf_fetched,
  output logic [31:0] perf_stall,
  output logic [31:0] perf_redirect
`endif
);
  typedef enum logic [1:0] {REQ, WAIT, HOLD} state_t;
  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic        drop_q, drop_d;
  logic        inst_valid_q, inst_valid_d;
  logic [31:0] inst_pc_q, inst_pc_d;
  logic [31:0] inst_out_q, inst_out_d;
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= REQ;
      pc_q         <= RESET_PC;
      drop_q       <= 1'b0;
      inst_valid_q <= 1'b0;
      inst_pc_q    <= 32'h0;
      inst_out_q   <= 32'h0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      drop_q       <= drop_d;
      inst_valid_q <= inst_valid_d;
      inst_pc_q    <= inst_pc_d;
      inst_out_q   <= inst_out_d;
    end
  end
  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    drop_d       = drop_q;
    inst_valid_d = inst_valid_q;
    inst_pc_d    = inst_pc_q;
    inst_out_d   = inst_out_q;
    if (redirect_valid) begin
      pc_d         = redirect_pc;
      inst_valid_d = 1'b0;
      case (state_q)
        // an accepted request still owes a response, which must be swallowed
        REQ: if (imem_ready) begin
          state_d = WAIT;
          drop_d  = 1'b1;
        end
        // a response arriving now is the stale one; otherwise remember to drop it
        WAIT: begin
          state_d = imem_rvalid ? REQ : WAIT;
          drop_d  = !imem_rvalid;
        end
        default: state_d = REQ;
      endcase
    end else begin
      case (state_q)
        REQ: state_d = imem_ready ? WAIT : REQ;
        WAIT: if (imem_rvalid) begin
          state_d = drop_q ? REQ : HOLD;
          drop_d  = 1'b0;
          if (!drop_q) begin
            inst_out_d   = imem_rdata;
            inst_pc_d    = pc_q;
            inst_valid_d = 1'b1;
            pc_d         = pc_q + 32'd1;
          end
        end
        HOLD: if (inst_ready) begin
          inst_valid_d = 1'b0;
          state_d      = REQ;
        end
        default: state_d = REQ;
      endcase
    end
  end
  assign imem_req   = state_q == REQ;
  assign imem_addr  = pc_q;
  assign inst_valid = inst_valid_q;
  assign inst_pc    = inst_pc_q;
  assign inst_out   = inst_out_q;
`ifdef FETCH_CTRL_PERF_EN
  logic [31:0] perf_fetched_q, perf_fetched_d;
  logic [31:0] perf_stall_q, perf_stall_d;
  logic [31:0] perf_redirect_q, perf_redirect_d;
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      perf_fetched_q  <= 32'h0;
      perf_stall_q    <= 32'h0;
      perf_redirect_q <= 32'h0;
    end else begin
      perf_fetched_q  <= perf_fetched_d;
      perf_stall_q    <= perf_stall_d;
      perf_redirect_q <= perf_redirect_d;
    end
  end
  always_comb begin
    perf_fetched_d  = perf_fetched_q + {31'd0, inst_valid_q && inst_ready};
    perf_stall_d    = perf_stall_q + {31'd0, inst_valid_q && !inst_ready};
    perf_redirect_d = perf_redirect_q + {31'd0, redirect_valid};
  end
  assign perf_fetched  = perf_fetched_q;
  assign perf_stall    = perf_stall_q;
  assign perf_redirect = perf_redirect_q;
`endif
endmodule
